// File: rtl/spi_flash_prog_seq.sv
// spi_flash_prog_seq: sequences optional sector erase, page program and WIP polling
// on a SPI flash command engine, streaming payload bytes from a caller page buffer.
module spi_flash_prog_seq #(
    parameter int          POLL_LIMIT = 20000,
    parameter logic [15:0] CLK_DIV    = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_prog_req,
    input  logic        i_erase_en,
    input  logic [23:0] i_prog_addr,
    input  logic [8:0]  i_prog_len,
    output logic [7:0]  o_buf_addr,
    input  logic [7:0]  i_buf_data,
    output logic [7:0]  o_cmd,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ack,
    output logic [23:0] o_addr,
    output logic [8:0]  o_byte_size,
    output logic [15:0] o_clk_div,
    input  logic        i_data_req,
    output logic [7:0]  o_data_in,
    input  logic [7:0]  i_data_out,
    input  logic        i_data_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);
    localparam logic [15:0] LIMIT = 16'(POLL_LIMIT);

    typedef enum logic [3:0] {
        IDLE, WREN_E, SE, POLL_E, WREN_P, PP_LOAD, PP, POLL_P, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        issued_q, issued_d, gap_q, gap_d, err_q, err_d, wip_q, wip_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  len_q, len_d;
    logic [7:0]  data_q, data_d, baddr_q, baddr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        is_poll, is_cmd, ack, wip;
    logic        unused_status;

    assign unused_status = ^i_data_out[7:1];

    always_comb begin
        is_poll     = (state_q == POLL_E) || (state_q == POLL_P);
        is_cmd      = (state_q != IDLE) && (state_q != PP_LOAD) && (state_q != DONE);
        // an ack only counts once this state's command has actually been launched
        ack         = i_cmd_ack && is_cmd && issued_q;
        wip         = i_data_valid ? i_data_out[0] : wip_q;
        o_cmd_valid = is_cmd && !issued_q && !gap_q;
        o_cmd       = (state_q == WREN_E || state_q == WREN_P) ? 8'h06 :
                      (state_q == SE) ? 8'hd8 : is_poll ? 8'h05 :
                      (state_q == PP) ? 8'h02 : 8'h00;
        o_addr      = (state_q == SE || state_q == PP) ? addr_q : 24'd0;
        o_byte_size = (state_q == PP) ? len_q : 9'd0;
        o_clk_div   = CLK_DIV;
        o_buf_addr  = baddr_q;
        o_data_in   = data_q;
        o_busy      = (state_q != IDLE) && (state_q != DONE);
        o_done      = (state_q == DONE);
        o_err       = err_q;
        state_d     = state_q;
        issued_d    = issued_q | o_cmd_valid;
        gap_d       = 1'b0;
        err_d       = err_q;
        wip_d       = (is_poll && i_data_valid) ? i_data_out[0] : wip_q;
        addr_d      = addr_q;
        len_d       = len_q;
        data_d      = data_q;
        baddr_d     = baddr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (i_prog_req) begin
                addr_d  = i_prog_addr;
                len_d   = (i_prog_len == 9'd0 || i_prog_len > 9'd256) ? 9'd256 : i_prog_len;
                err_d   = 1'b0;
                state_d = i_erase_en ? WREN_E : WREN_P;
            end
            WREN_E: if (ack) state_d = SE;
            SE: if (ack) begin
                state_d = POLL_E;
                cnt_d   = 16'd0;
            end
            POLL_E, POLL_P: if (ack) begin
                cnt_d = cnt_q + 16'd1;
                if (!wip) begin
                    state_d = (state_q == POLL_E) ? WREN_P : DONE;
                end else if (cnt_d >= LIMIT) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    issued_d = 1'b0;
                    gap_d    = 1'b1;
                end
            end
            WREN_P: if (ack) begin
                state_d = PP_LOAD;
                baddr_d = 8'd0;
            end
            // issued_q doubles as the one-cycle buffer read wait here
            PP_LOAD: if (issued_q) begin
                data_d  = i_buf_data;
                baddr_d = 8'd1;
                state_d = PP;
            end else begin
                issued_d = 1'b1;
            end
            PP: begin
                if (i_data_req) begin
                    data_d  = i_buf_data;
                    baddr_d = (baddr_q == 8'hff) ? baddr_q : baddr_q + 8'd1;
                end
                if (ack) begin
                    state_d = POLL_P;
                    cnt_d   = 16'd0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) issued_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            issued_q <= 1'b0;
            gap_q    <= 1'b0;
            err_q    <= 1'b0;
            wip_q    <= 1'b0;
            addr_q   <= 24'd0;
            len_q    <= 9'd0;
            data_q   <= 8'd0;
            baddr_q  <= 8'd0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
            wip_q    <= wip_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            data_q   <= data_d;
            baddr_q  <= baddr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_spi_flash_prog_seq.sv
// tb_spi_flash_prog_seq: directed erase/program/poll scenarios against a small flash
// engine model; expected events are queued up front and checked by a monitor.
module tb_spi_flash_prog_seq;
    typedef logic [49:0] ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_prog_req, i_erase_en;
    logic [23:0] i_prog_addr;
    logic [8:0]  i_prog_len;
    logic [7:0]  o_buf_addr, i_buf_data, o_cmd, o_data_in, i_data_out;
    logic        o_cmd_valid, i_cmd_ack, i_data_req, i_data_valid;
    logic [23:0] o_addr;
    logic [8:0]  o_byte_size;
    logic [15:0] o_clk_div;
    logic        o_busy, o_done, o_err;

    logic [7:0]  mem [256];
    ev_t         exp_q [$];
    int          n_checks = 0, n_fail = 0, wip_left = 0;
    logic        byte_strobe, aborted, inflight = 1'b0;
    logic [7:0]  held;

    spi_flash_prog_seq #(.POLL_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_prog_req(i_prog_req), .i_erase_en(i_erase_en),
        .i_prog_addr(i_prog_addr), .i_prog_len(i_prog_len), .o_buf_addr(o_buf_addr),
        .i_buf_data(i_buf_data), .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid),
        .i_cmd_ack(i_cmd_ack), .o_addr(o_addr), .o_byte_size(o_byte_size),
        .o_clk_div(o_clk_div), .i_data_req(i_data_req), .o_data_in(o_data_in),
        .i_data_out(i_data_out), .i_data_valid(i_data_valid), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // caller page buffer: synchronous read, data one cycle after the address
    always @(posedge clk) i_buf_data <= mem[o_buf_addr];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic sb(input string nm, input ev_t got);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got %h with no event expected", nm, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, got, e);
            end
        end
    endtask

    function automatic void push_cmd(input logic [7:0] c, input logic [23:0] a, input logic [8:0] s);
        exp_q.push_back({2'd1, 7'd0, s, a, c});
    endfunction

    function automatic void push_bytes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({2'd2, 40'd0, mem[i]});
    endfunction

    function automatic void push_done(input logic err);
        exp_q.push_back({2'd3, 46'd0, 1'b0, err});
    endfunction

    // monitor: every launch, delivered byte and completion is matched against the queue
    always @(negedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            if (o_cmd_valid) begin
                sb("cmd", {2'd1, 7'd0, (o_cmd == 8'h02) ? o_byte_size : 9'd0,
                           (o_cmd == 8'h02 || o_cmd == 8'hd8) ? o_addr : 24'd0, o_cmd});
                chk("single_launch", {63'd0, inflight}, 64'd0);
                held <= o_cmd;
            end else if (inflight) begin
                chk("cmd_stable", {56'd0, o_cmd}, {56'd0, held});
            end
            inflight <= o_cmd_valid ? 1'b1 : i_cmd_ack ? 1'b0 : inflight;
            if (byte_strobe) sb("pp_byte", {2'd2, 40'd0, o_data_in});
            if (o_done) sb("done", {2'd3, 46'd0, o_busy, o_err});
        end
    end

    task automatic eng_tick();
        @(posedge clk);
        #1;
        if (!rst_n) aborted = 1'b1;
    endtask

    // flash engine model: 2-cycle latency, RDSR status, PP byte requests spaced 4 cycles
    initial begin
        logic [7:0] cmd;
        int n;
        i_cmd_ack = 1'b0; i_data_req = 1'b0; i_data_valid = 1'b0;
        i_data_out = 8'd0; byte_strobe = 1'b0; aborted = 1'b0;
        forever begin
            if (rst_n === 1'b1 && o_cmd_valid === 1'b1) begin
                aborted = 1'b0;
                cmd = o_cmd;
                n = int'(o_byte_size);
                eng_tick();
                eng_tick();
                if (!aborted && cmd == 8'h05) begin
                    i_data_out = (wip_left > 0) ? 8'h03 : 8'h02;
                    if (wip_left > 0) wip_left--;
                    i_data_valid = 1'b1;
                    eng_tick();
                    i_data_valid = 1'b0;
                end
                if (cmd == 8'h02) begin
                    for (int i = 0; i < n && !aborted; i++) begin
                        byte_strobe = 1'b1;
                        eng_tick();
                        byte_strobe = 1'b0;
                        if (aborted) break;
                        i_data_req = 1'b1;
                        eng_tick();
                        i_data_req = 1'b0;
                        eng_tick();
                        eng_tick();
                    end
                end
                if (!aborted) begin
                    i_cmd_ack = 1'b1;
                    eng_tick();
                end
                i_cmd_ack = 1'b0; i_data_req = 1'b0; i_data_valid = 1'b0; byte_strobe = 1'b0;
            end else begin
                eng_tick();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic e, input logic [23:0] a, input logic [8:0] l);
        i_erase_en = e; i_prog_addr = a; i_prog_len = l; i_prog_req = 1'b1;
        step();
        i_prog_req = 1'b0;
        chk("busy_after_req", {63'd0, o_busy}, 64'd1);
        chk("err_clear_after_req", {63'd0, o_err}, 64'd0);
    endtask

    task automatic finish_op(input string nm, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = o_done;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no o_done within %0d cycles", nm, budget);
            exp_q.delete();
        end
        repeat (3) step();
        chk({nm, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_cmd_valid"}, {63'd0, o_cmd_valid}, 64'd0);
        chk({nm, "_busy"}, {63'd0, o_busy}, 64'd0);
        chk({nm, "_done"}, {63'd0, o_done}, 64'd0);
        chk({nm, "_err"}, {63'd0, o_err}, 64'd0);
        chk({nm, "_cmd"}, {56'd0, o_cmd}, 64'd0);
        chk({nm, "_addr"}, {40'd0, o_addr}, 64'd0);
        chk({nm, "_byte_size"}, {55'd0, o_byte_size}, 64'd0);
        chk({nm, "_data_in"}, {56'd0, o_data_in}, 64'd0);
        chk({nm, "_buf_addr"}, {56'd0, o_buf_addr}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11) ^ 8'h5a;
        rst_n = 1'b0; i_prog_req = 1'b0; i_erase_en = 1'b0; i_prog_addr = 24'd0; i_prog_len = 9'd0;
        repeat (3) step();
        chk_reset_outputs("reset");
        chk("clk_div", {48'd0, o_clk_div}, 64'd4);
        rst_n = 1'b1;
        step();

        // erase + program, WIP busy for two reads then clear
        wip_left = 2;
        push_cmd(8'h06, 24'd0, 9'd0); push_cmd(8'hd8, 24'h012300, 9'd0);
        repeat (3) push_cmd(8'h05, 24'd0, 9'd0);
        push_cmd(8'h06, 24'd0, 9'd0); push_cmd(8'h02, 24'h012300, 9'd4);
        push_bytes(4); push_cmd(8'h05, 24'd0, 9'd0); push_done(1'b0);
        start(1'b1, 24'h012300, 9'd4);
        finish_op("erase_prog", 400);

        // program only, single byte
        wip_left = 0;
        push_cmd(8'h06, 24'd0, 9'd0); push_cmd(8'h02, 24'h0000a5, 9'd1);
        push_bytes(1); push_cmd(8'h05, 24'd0, 9'd0); push_done(1'b0);
        start(1'b0, 24'h0000a5, 9'd1);
        finish_op("prog_only", 300);

        // erase poll timeout: WIP never clears
        wip_left = 1000;
        push_cmd(8'h06, 24'd0, 9'd0); push_cmd(8'hd8, 24'h3f0000, 9'd0);
        repeat (4) push_cmd(8'h05, 24'd0, 9'd0);
        push_done(1'b1);
        start(1'b1, 24'h3f0000, 9'd8);
        finish_op("timeout", 400);
        chk("err_held", {63'd0, o_err}, 64'd1);

        // len 0 means a full 256-byte page
        wip_left = 0;
        push_cmd(8'h06, 24'd0, 9'd0); push_cmd(8'h02, 24'habcdef, 9'd256);
        push_bytes(256); push_cmd(8'h05, 24'd0, 9'd0); push_done(1'b0);
        start(1'b0, 24'habcdef, 9'd0);
        finish_op("len0", 3000);
        chk("buf_addr_saturated", {56'd0, o_buf_addr}, 64'd255);

        // over-long length clamps to 256
        push_cmd(8'h06, 24'd0, 9'd0); push_cmd(8'h02, 24'h000400, 9'd256);
        push_bytes(256); push_cmd(8'h05, 24'd0, 9'd0); push_done(1'b0);
        start(1'b0, 24'h000400, 9'd300);
        finish_op("len_clamp", 3000);

        // a second request while busy must be ignored
        push_cmd(8'h06, 24'd0, 9'd0); push_cmd(8'h02, 24'h000100, 9'd2);
        push_bytes(2); push_cmd(8'h05, 24'd0, 9'd0); push_done(1'b0);
        start(1'b0, 24'h000100, 9'd2);
        repeat (3) step();
        start(1'b1, 24'hffffff, 9'd5);
        finish_op("req_while_busy", 400);

        // reset in the middle of PP abandons the sequence
        push_cmd(8'h06, 24'd0, 9'd0); push_cmd(8'h02, 24'h111111, 9'd8); push_bytes(8);
        start(1'b0, 24'h111111, 9'd8);
        begin
            logic seen_pp = 1'b0;
            for (int i = 0; i < 200 && !seen_pp; i++) begin
                @(negedge clk);
                seen_pp = o_cmd_valid && (o_cmd == 8'h02);
            end
            chk("pp_reached_before_reset", {63'd0, seen_pp}, 64'd1);
        end
        repeat (5) step();
        rst_n = 1'b0;
        step();
        chk_reset_outputs("mid_pp_reset");
        step();
        exp_q.delete();
        rst_n = 1'b1;
        step();

        // normal operation after the abandoned one
        push_cmd(8'h06, 24'd0, 9'd0); push_cmd(8'h02, 24'h222222, 9'd3);
        push_bytes(3); push_cmd(8'h05, 24'd0, 9'd0); push_done(1'b0);
        start(1'b0, 24'h222222, 9'd3);
        finish_op("after_reset", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
